ghost_bank_src: RTL and testbench

- Multi-channel successor of the single-ghost sprite source. Renders N_GHOST ghosts from one shared sprite sheet in RAM.
- Each ghost has its own position/control registers, direction-aware animation, and a mode: normal, frightened (self-timed, blinking) or eyes-only.
- Sits in the video pixel pipeline between the frame counter (x, y) and the layer blender. Driven by the CPU through a register write port.

---
 rtl/ghost_pkg.sv | 80 ++++++++
 rtl/ghost_chan.sv | 136 +++++++++++++
 rtl/ghost_bank_src.sv | 197 +++++++++++++++++++
 tb/tb_ghost_bank_src.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types, register field positions, colours and frame bases
// for the multi-ghost sprite source (ghost_bank_src / ghost_chan).
package ghost_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FRIGHT = 2'd1,
    EYES   = 2'd2
  } ghost_mode_t;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } ghost_dir_t;

  // 2-bit palette codes stored in the sprite sheet
  typedef enum logic [1:0] {
    PIX_CLEAR   = 2'd0,
    PIX_OUTLINE = 2'd1,
    PIX_BODY    = 2'd2,
    PIX_WHITE   = 2'd3
  } pix_code_t;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned REL_W   = 12;
  localparam int unsigned FRAME_W = 4;
  localparam int unsigned TIMER_W = 8;

  // Position register fields
  localparam int unsigned POS_X_LSB = 0;
  localparam int unsigned POS_Y_LSB = 16;

  // Control register fields
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_AUTO_BIT  = 1;
  localparam int unsigned CTRL_COL_LSB   = 2;
  localparam int unsigned CTRL_DIR_LSB   = 4;
  localparam int unsigned CTRL_MODE_LSB  = 6;
  localparam int unsigned CTRL_FRAME_LSB = 8;
  localparam int unsigned CTRL_FF_LSB    = 12;

  localparam logic [11:0] COL_RED     = 12'hf00;
  localparam logic [11:0] COL_PINK    = 12'hf8b;
  localparam logic [11:0] COL_ORANGE  = 12'hfa0;
  localparam logic [11:0] COL_CYAN    = 12'h0ff;
  localparam logic [11:0] COL_OUTLINE = 12'h111;
  localparam logic [11:0] COL_WHITE   = 12'hfff;
  localparam logic [11:0] COL_FRIGHT  = 12'h00f;

  localparam int unsigned FRAME_FRIGHT = 8;
  localparam int unsigned FRAME_EYES   = 10;

  // Per-ghost attributes carried alongside the RAM read
  typedef struct packed {
    ghost_mode_t        mode;
    logic [1:0]         colour;
    logic [TIMER_W-1:0] timer;
  } ghost_attr_t;

  function automatic logic [11:0] body_colour(input logic [1:0] sel);
    case (sel)
      2'd0:    return COL_RED;
      2'd1:    return COL_PINK;
      2'd2:    return COL_ORANGE;
      default: return COL_CYAN;
    endcase
  endfunction

  // Reserved encoding 3 is treated as normal
  function automatic ghost_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return FRIGHT;
      2'd2:    return EYES;
      default: return NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/ghost_chan.sv
// ghost_chan: one ghost channel. Holds position/control registers and the
// frightened timer, and computes bounding-box membership and RAM read address.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_wr_pos/i_wr_ctrl register write strobes for this channel
//   i_wr_data         register write data
//   i_frame_tick      one pulse per frame
//   i_ani_bit         shared animation phase
//   i_x, i_y          current pixel coordinate
//   o_in_region_c     pixel lies inside this enabled ghost's box (comb)
//   o_rd_addr_c       sprite RAM address {frame, row, col} (comb)
//   o_attr            registered mode/colour/timer
//   o_fright          registered frightened status
module ghost_chan
  import ghost_pkg::*;
#(
  parameter int unsigned SIZE_LOG2 = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_wr_pos,
  input  logic                            i_wr_ctrl,
  input  logic [31:0]                     i_wr_data,
  input  logic                            i_frame_tick,
  input  logic                            i_ani_bit,
  input  logic [COORD_W-1:0]              i_x,
  input  logic [COORD_W-1:0]              i_y,
  output logic                            o_in_region_c,
  output logic [FRAME_W+2*SIZE_LOG2-1:0]  o_rd_addr_c,
  output ghost_attr_t                     o_attr,
  output logic                            o_fright
);

  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_y0;
  logic               r_en;
  logic               r_auto;
  logic [1:0]         r_colour;
  ghost_dir_t         r_dir;
  ghost_mode_t        r_mode;
  logic [FRAME_W-1:0] r_man_frame;
  logic [TIMER_W-1:0] r_timer;
  logic               r_fright;

  ghost_mode_t        w_mode_nxt;
  ghost_mode_t        w_wr_mode;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [TIMER_W-1:0] w_wr_ff;
  logic [FRAME_W-1:0] w_frame;
  logic [REL_W-1:0]   w_xr;
  logic [REL_W-1:0]   w_yr;
  logic               w_unused_data;

  assign w_wr_mode     = decode_mode(i_wr_data[CTRL_MODE_LSB +: 2]);
  assign w_wr_ff       = i_wr_data[CTRL_FF_LSB +: TIMER_W];
  assign w_unused_data = ^i_wr_data[31:27];

  // Mode/timer next state: a control write always beats a same-cycle tick
  always_comb begin
    w_mode_nxt  = r_mode;
    w_timer_nxt = r_timer;
    if (i_wr_ctrl) begin
      if (w_wr_mode == FRIGHT) begin
        w_timer_nxt = w_wr_ff;
        w_mode_nxt  = (w_wr_ff == '0) ? NORMAL : FRIGHT;
      end else begin
        // Clear the timer so a stale countdown cannot override this mode
        w_timer_nxt = '0;
        w_mode_nxt  = w_wr_mode;
      end
    end else if (i_frame_tick && (r_timer != '0)) begin
      w_timer_nxt = r_timer - TIMER_W'(1);
      if (r_timer == TIMER_W'(1)) begin
        w_mode_nxt = NORMAL;
      end
    end
  end

  // Register file and frightened state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0        <= '0;
      r_y0        <= '0;
      r_en        <= 1'b0;
      r_auto      <= 1'b0;
      r_colour    <= '0;
      r_dir       <= DIR_R;
      r_man_frame <= '0;
      r_mode      <= NORMAL;
      r_timer     <= '0;
      r_fright    <= 1'b0;
    end else begin
      if (i_wr_pos) begin
        r_x0 <= i_wr_data[POS_X_LSB +: COORD_W];
        r_y0 <= i_wr_data[POS_Y_LSB +: COORD_W];
      end
      if (i_wr_ctrl) begin
        r_en        <= i_wr_data[CTRL_EN_BIT];
        r_auto      <= i_wr_data[CTRL_AUTO_BIT];
        r_colour    <= i_wr_data[CTRL_COL_LSB +: 2];
        r_dir       <= ghost_dir_t'(i_wr_data[CTRL_DIR_LSB +: 2]);
        r_man_frame <= i_wr_data[CTRL_FRAME_LSB +: FRAME_W];
      end
      r_mode   <= w_mode_nxt;
      r_timer  <= w_timer_nxt;
      r_fright <= (w_mode_nxt == FRIGHT);
    end
  end

  // Frame selection
  always_comb begin
    w_frame = r_man_frame;
    if (r_auto) begin
      case (r_mode)
        FRIGHT:  w_frame = FRAME_W'(FRAME_FRIGHT) + {3'b000, i_ani_bit};
        EYES:    w_frame = FRAME_W'(FRAME_EYES) + {2'b00, r_dir};
        default: w_frame = {1'b0, r_dir, i_ani_bit};
      endcase
    end
  end

  // 12-bit two's-complement offsets; bit 11 set means the pixel is left/above
  assign w_xr = REL_W'(i_x) - REL_W'(r_x0);
  assign w_yr = REL_W'(i_y) - REL_W'(r_y0);

  assign o_in_region_c = r_en
                      && (w_xr[REL_W-1:SIZE_LOG2] == '0)
                      && (w_yr[REL_W-1:SIZE_LOG2] == '0);
  assign o_rd_addr_c   = {w_frame, w_yr[SIZE_LOG2-1:0], w_xr[SIZE_LOG2-1:0]};

  assign o_attr.mode   = r_mode;
  assign o_attr.colour = r_colour;
  assign o_attr.timer  = r_timer;
  assign o_fright      = r_fright;

endmodule

// File: rtl/ghost_bank_src.sv
// ghost_bank_src: renders N_GHOST ghosts from one shared 2-bit sprite sheet.
// Pipeline: channel hit-test + priority select -> sync RAM read -> palette
// lookup into the output register (2 clocks from x,y to sprite_rgb/hit).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   x, y                 current pixel coordinate
//   wr_en/wr_addr/wr_data CPU register write {ghost index, sel}; sel 1 = control
//   sp_we/sp_addr/sp_pixel sprite RAM write {frame, row, col}
//   sprite_rgb, hit      output pixel and opaque-ghost flag
//   fright_active        per-ghost frightened status
module ghost_bank_src
  import ghost_pkg::*;
#(
  parameter int unsigned CD          = 12,
  parameter int unsigned N_GHOST     = 4,
  parameter int unsigned SIZE_LOG2   = 5,
  parameter int unsigned ANI_DIV     = 10,
  parameter int unsigned BLINK_START = 120,
  parameter int unsigned KEY_COLOR   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [10:0]                   x,
  input  logic [10:0]                   y,
  input  logic                          wr_en,
  input  logic [$clog2(N_GHOST):0]      wr_addr,
  input  logic [31:0]                   wr_data,
  input  logic                          sp_we,
  input  logic [4+2*SIZE_LOG2-1:0]      sp_addr,
  input  logic [1:0]                    sp_pixel,
  output logic [CD-1:0]                 sprite_rgb,
  output logic                          hit,
  output logic [N_GHOST-1:0]            fright_active
);

  localparam int unsigned WA_W      = $clog2(N_GHOST) + 1;
  localparam int unsigned AW        = FRAME_W + 2 * SIZE_LOG2;
  localparam int unsigned RAM_DEPTH = 1 << AW;
  localparam int unsigned ANI_W     = (ANI_DIV > 1) ? $clog2(ANI_DIV) : 1;

  // Frame tick and shared animation phase
  logic [COORD_W-1:0] r_x_prev;
  logic [ANI_W-1:0]   r_ani_cnt;
  logic               r_ani_bit;
  logic               w_frame_tick;

  assign w_frame_tick = (r_x_prev == '0) && (x == COORD_W'(1)) && (y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_prev  <= '0;
      r_ani_cnt <= '0;
      r_ani_bit <= 1'b0;
    end else begin
      r_x_prev <= x;
      if (w_frame_tick) begin
        if (r_ani_cnt == ANI_W'(ANI_DIV - 1)) begin
          r_ani_cnt <= '0;
          r_ani_bit <= ~r_ani_bit;
        end else begin
          r_ani_cnt <= r_ani_cnt + ANI_W'(1);
        end
      end
    end
  end

  // Write decode; indices past N_GHOST match no channel and are dropped
  logic [WA_W-1:0]   w_wr_idx;
  logic [N_GHOST-1:0] w_in;
  logic [AW-1:0]     w_ch_addr [N_GHOST];
  ghost_attr_t       w_ch_attr [N_GHOST];

  assign w_wr_idx = wr_addr >> 1;

  for (genvar g = 0; g < N_GHOST; g++) begin : g_chan
    logic w_sel;
    assign w_sel = wr_en && (w_wr_idx == WA_W'(g));

    ghost_chan #(
      .SIZE_LOG2(SIZE_LOG2)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_wr_pos     (w_sel && !wr_addr[0]),
      .i_wr_ctrl    (w_sel && wr_addr[0]),
      .i_wr_data    (wr_data),
      .i_frame_tick (w_frame_tick),
      .i_ani_bit    (r_ani_bit),
      .i_x          (x),
      .i_y          (y),
      .o_in_region_c(w_in[g]),
      .o_rd_addr_c  (w_ch_addr[g]),
      .o_attr       (w_ch_attr[g]),
      .o_fright     (fright_active[g])
    );
  end

  // Stage 0: lowest-index ghost whose box contains the pixel owns it
  logic        w_s0_valid;
  logic [AW-1:0] w_s0_addr;
  ghost_attr_t w_s0_attr;

  always_comb begin
    w_s0_valid = 1'b0;
    w_s0_addr  = '0;
    w_s0_attr  = '0;
    for (int i = N_GHOST - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        w_s0_valid = 1'b1;
        w_s0_addr  = w_ch_addr[i];
        w_s0_attr  = w_ch_attr[i];
      end
    end
  end

  // Sprite sheet storage; contents survive reset
  logic [1:0] r_mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (sp_we) begin
      r_mem[sp_addr] <= sp_pixel;
    end
  end

  // Stage 1: synchronous read (old data on same-address write) plus attributes
  pix_code_t   r_s1_code;
  logic        r_s1_valid;
  ghost_attr_t r_s1_attr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_code  <= PIX_CLEAR;
      r_s1_valid <= 1'b0;
      r_s1_attr  <= '0;
    end else begin
      r_s1_code  <= pix_code_t'(r_mem[w_s0_addr]);
      r_s1_valid <= w_s0_valid;
      r_s1_attr  <= w_s0_attr;
    end
  end

  // Stage 2: palette lookup; a clear pixel of the winner stays transparent
  logic [CD-1:0] w_rgb;
  logic          w_hit;
  logic          w_blink;

  assign w_blink = (32'(r_s1_attr.timer) < BLINK_START) && r_s1_attr.timer[3];

  always_comb begin
    w_rgb = CD'(KEY_COLOR);
    w_hit = 1'b0;
    if (r_s1_valid) begin
      case (r_s1_code)
        PIX_OUTLINE: begin
          w_rgb = CD'(COL_OUTLINE);
          w_hit = 1'b1;
        end
        PIX_WHITE: begin
          w_rgb = CD'(COL_WHITE);
          w_hit = 1'b1;
        end
        PIX_BODY: begin
          case (r_s1_attr.mode)
            FRIGHT: begin
              w_rgb = w_blink ? CD'(COL_WHITE) : CD'(COL_FRIGHT);
              w_hit = 1'b1;
            end
            EYES: begin
              w_rgb = CD'(KEY_COLOR);
              w_hit = 1'b0;
            end
            default: begin
              w_rgb = CD'(body_colour(r_s1_attr.colour));
              w_hit = 1'b1;
            end
          endcase
        end
        default: begin
          w_rgb = CD'(KEY_COLOR);
          w_hit = 1'b0;
        end
      endcase
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_rgb <= CD'(KEY_COLOR);
      hit        <= 1'b0;
    end else begin
      sprite_rgb <= w_rgb;
      hit        <= w_hit;
    end
  end

endmodule

// File: tb/tb_ghost_bank_src.sv
// tb_ghost_bank_src: directed self-checking bench for ghost_bank_src.
module tb_ghost_bank_src;

  localparam int unsigned CD        = 12;
  localparam int unsigned N_GHOST   = 4;
  localparam int unsigned SIZE_LOG2 = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x;
  logic [10:0] y;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        sp_we;
  logic [13:0] sp_addr;
  logic [1:0]  sp_pixel;
  logic [11:0] sprite_rgb;
  logic        hit;
  logic [3:0]  fright_active;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ghost_bank_src #(
    .CD(CD), .N_GHOST(N_GHOST), .SIZE_LOG2(SIZE_LOG2),
    .ANI_DIV(10), .BLINK_START(120), .KEY_COLOR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sp_we(sp_we), .sp_addr(sp_addr), .sp_pixel(sp_pixel),
    .sprite_rgb(sprite_rgb), .hit(hit), .fright_active(fright_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a pixel and check the result two clocks later
  task automatic probe(input logic [10:0] px, input logic [10:0] py,
                       input logic [11:0] rgb, input logic h, input string tag);
    @(negedge clk);
    x = px;
    y = py;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, 32'(sprite_rgb), 32'(rgb));
    check({tag, "_hit"}, 32'(hit), 32'(h));
  endtask

  task automatic reg_wr(input logic [1:0] g, input logic sel, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = {g, sel};
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic ram_wr(input logic [3:0] fr, input logic [4:0] row,
                        input logic [4:0] col, input logic [1:0] code);
    @(negedge clk);
    sp_we    = 1'b1;
    sp_addr  = {fr, row, col};
    sp_pixel = code;
    @(negedge clk);
    sp_we    = 1'b0;
  endtask

  // Exactly one frame_tick: x goes 0 -> 1 on line 0
  task automatic tick();
    @(negedge clk);
    x = 11'd0;
    y = 11'd0;
    @(negedge clk);
    x = 11'd1;
    @(negedge clk);
    x = 11'd500;
    y = 11'd500;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; x = 11'd500; y = 11'd500;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sp_we = 1'b0; sp_addr = '0; sp_pixel = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rgb", 32'(sprite_rgb), 32'h000);
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_fright", 32'(fright_active), 32'h0);
    rst_n = 1'b1;
    probe(11'd103, 11'd52, 12'h000, 1'b0, "idle_a");
    probe(11'd2047, 11'd2047, 12'h000, 1'b0, "idle_b");

    // Ghost0 at (100,50), pink, manual frame 0
    ram_wr(4'd0, 5'd2, 5'd3, 2'b10);
    ram_wr(4'd0, 5'd2, 5'd4, 2'b01);
    ram_wr(4'd0, 5'd2, 5'd5, 2'b11);
    ram_wr(4'd0, 5'd2, 5'd31, 2'b11);
    reg_wr(2'd0, 1'b0, (32'd50 << 16) | 32'd100);
    reg_wr(2'd0, 1'b1, 32'h0000_0005);
    probe(11'd99, 11'd52, 12'h000, 1'b0, "g0_left_edge");
    // Latency: one clock after changing x the old result is still shown
    @(negedge clk);
    x = 11'd103;
    y = 11'd52;
    @(posedge clk);
    #1;
    check("lat_1clk_rgb", 32'(sprite_rgb), 32'h000);
    @(posedge clk);
    #1;
    check("lat_2clk_rgb", 32'(sprite_rgb), 32'hf8b);
    check("lat_2clk_hit", 32'(hit), 32'h1);
    probe(11'd104, 11'd52, 12'h111, 1'b1, "g0_outline");
    probe(11'd105, 11'd52, 12'hfff, 1'b1, "g0_white");
    probe(11'd131, 11'd52, 12'hfff, 1'b1, "g0_col31");
    probe(11'd132, 11'd52, 12'h000, 1'b0, "g0_col32");
    probe(11'd103, 11'd82, 12'h000, 1'b0, "g0_row32");

    // Ghost0 and ghost2 overlap; ghost0's clear pixel hides ghost2
    ram_wr(4'd0, 5'd5, 5'd10, 2'b00);
    ram_wr(4'd1, 5'd5, 5'd10, 2'b10);
    reg_wr(2'd0, 1'b0, (32'd200 << 16) | 32'd200);
    reg_wr(2'd2, 1'b0, (32'd200 << 16) | 32'd200);
    reg_wr(2'd2, 1'b1, 32'h0000_010D);
    probe(11'd210, 11'd205, 12'h000, 1'b0, "overlap_clear");
    reg_wr(2'd0, 1'b1, 32'h0000_0004);
    probe(11'd210, 11'd205, 12'h0ff, 1'b1, "overlap_g2");

    // Ghost1 frightened for 130 frames, manual frame 2
    ram_wr(4'd2, 5'd0, 5'd0, 2'b10);
    reg_wr(2'd1, 1'b0, (32'd300 << 16) | 32'd400);
    reg_wr(2'd1, 1'b1, 32'h0008_2241);
    check("fr_start", 32'(fright_active), 32'h2);
    probe(11'd400, 11'd300, 12'h00f, 1'b1, "fr_t130");
    for (int k = 0; k < 10; k++) tick();
    probe(11'd400, 11'd300, 12'h00f, 1'b1, "fr_t120");
    for (int k = 0; k < 9; k++) tick();
    probe(11'd400, 11'd300, 12'hfff, 1'b1, "fr_t111");
    for (int k = 0; k < 8; k++) tick();
    probe(11'd400, 11'd300, 12'h00f, 1'b1, "fr_t103");
    for (int k = 0; k < 102; k++) tick();
    check("fr_t1", 32'(fright_active), 32'h2);
    tick();
    check("fr_t0", 32'(fright_active), 32'h0);
    probe(11'd400, 11'd300, 12'hf00, 1'b1, "fr_done_red");

    // Fresh animation phase: auto frames, edge handling
    reset_dut();
    check("rst2_fright", 32'(fright_active), 32'h0);
    ram_wr(4'd4, 5'd1, 5'd1, 2'b10);
    ram_wr(4'd5, 5'd1, 5'd1, 2'b11);
    ram_wr(4'd13, 5'd1, 5'd1, 2'b10);
    ram_wr(4'd13, 5'd1, 5'd2, 2'b11);
    ram_wr(4'd8, 5'd1, 5'd1, 2'b10);
    ram_wr(4'd1, 5'd1, 5'd5, 2'b10);
    ram_wr(4'd1, 5'd1, 5'd13, 2'b10);
    reg_wr(2'd2, 1'b0, (32'd100 << 16) | 32'd2040);
    reg_wr(2'd2, 1'b1, 32'h0000_010D);
    probe(11'd2045, 11'd101, 12'h0ff, 1'b1, "edge_in");
    probe(11'd5, 11'd101, 12'h000, 1'b0, "edge_nowrap");

    reg_wr(2'd3, 1'b0, (32'd400 << 16) | 32'd600);
    reg_wr(2'd3, 1'b1, 32'h0000_002B);
    probe(11'd601, 11'd401, 12'hfa0, 1'b1, "auto_f4_a");
    for (int k = 0; k < 9; k++) tick();
    probe(11'd601, 11'd401, 12'hfa0, 1'b1, "auto_f4_b");
    tick();
    probe(11'd601, 11'd401, 12'hfff, 1'b1, "auto_f5");
    for (int k = 0; k < 10; k++) tick();
    probe(11'd601, 11'd401, 12'hfa0, 1'b1, "auto_f4_c");
    reg_wr(2'd3, 1'b1, 32'h0000_00BB);
    probe(11'd601, 11'd401, 12'h000, 1'b0, "eyes_body");
    probe(11'd602, 11'd401, 12'hfff, 1'b1, "eyes_white");
    check("eyes_fright", 32'(fright_active), 32'h0);

    // Control write coincident with a frame tick: timer loads 8, not 7
    @(negedge clk);
    x = 11'd0;
    y = 11'd0;
    @(negedge clk);
    x = 11'd1;
    wr_en   = 1'b1;
    wr_addr = {2'd3, 1'b1};
    wr_data = 32'h0000_806B;
    @(negedge clk);
    wr_en = 1'b0;
    x = 11'd500;
    y = 11'd500;
    check("coinc_fright", 32'(fright_active), 32'h8);
    probe(11'd601, 11'd401, 12'hfff, 1'b1, "coinc_t8");
    tick();
    probe(11'd601, 11'd401, 12'h00f, 1'b1, "coinc_t7");
    for (int k = 0; k < 7; k++) tick();
    check("coinc_t0", 32'(fright_active), 32'h0);
    probe(11'd601, 11'd401, 12'hfa0, 1'b1, "coinc_normal");
    reg_wr(2'd3, 1'b1, 32'h0000_006B);
    check("fr_zero_frames", 32'(fright_active), 32'h0);
    probe(11'd601, 11'd401, 12'hfa0, 1'b1, "fr_zero_pix");

    // Reset asserted mid-line flushes the output at once
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", 32'(sprite_rgb), 32'h000);
    check("midrst_hit", 32'(hit), 32'h0);
    @(posedge clk);
    #1;
    check("midrst_rgb_clk", 32'(sprite_rgb), 32'h000);
    @(negedge clk);
    rst_n = 1'b1;
    probe(11'd601, 11'd401, 12'h000, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
